// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN serial feed path.
// Holds the serializer state encoding and width helpers.
package bnn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int IMG_BITS  = 784;
    localparam int FC_WORD_W = 32;

    // Bits needed to index n items; never narrower than 1.
    function automatic int wbits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bnn_word_fifo.sv
// Small synchronous word FIFO with registered occupancy count.
// Head word is visible on dout whenever the FIFO is non-empty.
module bnn_word_fifo
    import bnn_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic [W-1:0]            din,
    input  logic                    pop,
    output logic [W-1:0]            dout,
    output logic                    full,
    output logic                    empty,
    output logic [wbits(DEPTH):0]   count
);

    localparam int AW = wbits(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and count; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bnn_bit_serializer.sv
// Parallel-to-serial feeder for one BNN input lane.
// Buffers host words, shifts them out LSB-first and frames them.
module bnn_bit_serializer
    import bnn_pkg::*;
#(
    parameter int WORD_W     = FC_WORD_W,
    parameter int FIFO_DEPTH = 8,
    parameter int FRAME_BITS = IMG_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              bit_en,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              frame_done,
    output logic              underrun,
    input  logic              abort,
    output logic              busy
);

    localparam int RW = wbits(WORD_W + 1);
    localparam int FW = wbits(FRAME_BITS);
    localparam int CW = wbits(FIFO_DEPTH) + 1;

    ser_state_t        state_q;
    ser_state_t        state_d;
    logic [WORD_W-1:0] shreg_q;
    logic [WORD_W-1:0] shreg_d;
    logic [RW-1:0]     rem_q;
    logic [RW-1:0]     rem_d;
    logic [FW-1:0]     fcnt_q;
    logic [FW-1:0]     fcnt_d;
    logic              bit_out_d;
    logic              bit_valid_d;
    logic              frame_done_d;
    logic              underrun_d;

    logic              push;
    logic              pop;
    logic [WORD_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    logic              last_bit;
    logic              frame_last;

    bnn_word_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .push  (push),
        .din   (s_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign s_ready    = ~fifo_full;
    assign busy       = (fifo_count != '0) | (state_q == SHIFT);
    assign last_bit   = (rem_q == RW'(1));
    assign frame_last = (fcnt_q == FW'(FRAME_BITS - 1));

    // Next-state, shifter, counters and handshake decisions.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        rem_d        = rem_q;
        fcnt_d       = fcnt_q;
        bit_out_d    = bit_out;
        bit_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = underrun;
        push         = 1'b0;
        pop          = 1'b0;

        if (abort) begin
            state_d    = IDLE;
            rem_d      = '0;
            fcnt_d     = '0;
            underrun_d = 1'b0;
        end else begin
            push = s_valid & s_ready;
            unique case (state_q)
                IDLE: begin
                    if (bit_en) begin
                        underrun_d = 1'b1;
                    end
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_dout;
                        rem_d   = RW'(WORD_W);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_en) begin
                        bit_out_d    = shreg_q[0];
                        bit_valid_d  = 1'b1;
                        shreg_d      = shreg_q >> 1;
                        rem_d        = rem_q - RW'(1);
                        frame_done_d = frame_last;
                        fcnt_d       = frame_last ? '0 : fcnt_q + FW'(1);
                        // Word exhausted or frame padding dropped.
                        if (last_bit || frame_last) begin
                            if (!fifo_empty) begin
                                pop     = 1'b1;
                                shreg_d = fifo_dout;
                                rem_d   = RW'(WORD_W);
                                state_d = SHIFT;
                            end else begin
                                rem_d   = '0;
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            rem_q      <= '0;
            fcnt_q     <= '0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            rem_q      <= rem_d;
            fcnt_q     <= fcnt_d;
            bit_out    <= bit_out_d;
            bit_valid  <= bit_valid_d;
            frame_done <= frame_done_d;
            underrun   <= underrun_d;
        end
    end

endmodule

// File: tb/tb_bnn_bit_serializer.sv
// Directed bench for bnn_bit_serializer.
// Lane a uses 40-bit frames, lane b the full 784-bit image frame.
module tb_bnn_bit_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        bit_en;
    logic        bit_out;
    logic        bit_valid;
    logic        frame_done;
    logic        underrun;
    logic        abort;
    logic        busy;

    logic        b_rst;
    logic        b_s_valid;
    logic        b_s_ready;
    logic [31:0] b_s_data;
    logic        b_bit_en;
    logic        b_bit_out;
    logic        b_bit_valid;
    logic        b_frame_done;
    logic        b_underrun;
    logic        b_abort;
    logic        b_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bnn_bit_serializer #(
        .WORD_W     (32),
        .FIFO_DEPTH (8),
        .FRAME_BITS (40)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .bit_en     (bit_en),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .frame_done (frame_done),
        .underrun   (underrun),
        .abort      (abort),
        .busy       (busy)
    );

    bnn_bit_serializer #(
        .WORD_W     (32),
        .FIFO_DEPTH (8),
        .FRAME_BITS (784)
    ) dut_b (
        .clk        (clk),
        .rst        (b_rst),
        .s_valid    (b_s_valid),
        .s_ready    (b_s_ready),
        .s_data     (b_s_data),
        .bit_en     (b_bit_en),
        .bit_out    (b_bit_out),
        .bit_valid  (b_bit_valid),
        .frame_done (b_frame_done),
        .underrun   (b_underrun),
        .abort      (b_abort),
        .busy       (b_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int k);
        return 32'h9E3779B9 * (k + 1);
    endfunction

    // Push two words back-to-back, then stream n bits with bit_en held.
    task automatic push2_emit(input logic [31:0] w0, input logic [31:0] w1,
                              input int n, input int done_idx);
        logic e;
        s_valid = 1'b1;
        s_data  = w0;
        step();
        s_data  = w1;
        step();
        s_valid = 1'b0;
        bit_en  = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            e = (i < 32) ? w0[i] : w1[i-32];
            chk("p2_valid", {31'd0, bit_valid}, 32'd1);
            chk("p2_bit", {31'd0, bit_out}, {31'd0, e});
            chk("p2_done", {31'd0, frame_done}, {31'd0, i == done_idx});
            if (i == done_idx) begin
                chk("p2_busy_end", {31'd0, busy}, 32'd0);
            end
            if (i == n - 1) begin
                bit_en = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] w;
        logic        r;
        logic        v;
        int          pushed;
        int          guard;

        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        bit_en    = 1'b0;
        abort     = 1'b0;
        b_rst     = 1'b1;
        b_s_valid = 1'b0;
        b_s_data  = '0;
        b_bit_en  = 1'b0;
        b_abort   = 1'b0;
        step();
        step();
        rst   = 1'b0;
        b_rst = 1'b0;

        chk("rst_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_bit", {31'd0, bit_out}, 32'd0);
        chk("rst_valid", {31'd0, bit_valid}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_under", {31'd0, underrun}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Single word 0x5: first bit_valid two edges after the push.
        s_valid = 1'b1;
        s_data  = 32'h0000_0005;
        step();
        s_valid = 1'b0;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        step();
        chk("t1_nvalid", {31'd0, bit_valid}, 32'd0);
        bit_en = 1'b1;
        w = 32'h0000_0005;
        for (int i = 0; i < 32; i++) begin
            step();
            chk("t1_valid", {31'd0, bit_valid}, 32'd1);
            chk("t1_bit", {31'd0, bit_out}, {31'd0, w[i]});
            chk("t1_done", {31'd0, frame_done}, 32'd0);
            if (i == 31) begin
                bit_en = 1'b0;
            end
        end
        step();
        chk("t1_idle_valid", {31'd0, bit_valid}, 32'd0);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);
        chk("t1_under", {31'd0, underrun}, 32'd0);

        // Fresh frame: 32 ones then 0xAA, frame ends on bit 39.
        rst = 1'b1;
        step();
        rst = 1'b0;
        push2_emit(32'hFFFF_FFFF, 32'h0000_00AA, 40, 39);
        step();
        chk("t2_valid_off", {31'd0, bit_valid}, 32'd0);
        chk("t2_done_off", {31'd0, frame_done}, 32'd0);
        chk("t2_busy", {31'd0, busy}, 32'd0);

        // Fill: first word goes to the shifter, eight more fill the FIFO.
        s_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            s_data = 32'h1000_0000 + 32'(k) * 32'h0101_0101;
            step();
            chk("t3_ready", {31'd0, s_ready}, {31'd0, k < 8});
        end
        s_data = 32'hCAFE_F00D;
        step();
        step();
        chk("t3_blocked", {31'd0, s_ready}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        s_valid = 1'b0;
        bit_en  = 1'b1;
        w = 32'h1000_0000;
        for (int i = 0; i < 32; i++) begin
            step();
            chk("t3_valid", {31'd0, bit_valid}, 32'd1);
            chk("t3_bit", {31'd0, bit_out}, {31'd0, w[i]});
            chk("t3_ready_rel", {31'd0, s_ready}, {31'd0, i == 31});
        end
        bit_en = 1'b0;
        step();
        chk("t3_stop", {31'd0, bit_valid}, 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t3_abort_busy", {31'd0, busy}, 32'd0);
        chk("t3_abort_ready", {31'd0, s_ready}, 32'd1);

        // Underrun is sticky across a push and cleared by abort.
        bit_en = 1'b1;
        step();
        bit_en = 1'b0;
        chk("t4_valid", {31'd0, bit_valid}, 32'd0);
        chk("t4_under", {31'd0, underrun}, 32'd1);
        s_valid = 1'b1;
        s_data  = 32'h0000_0003;
        step();
        s_valid = 1'b0;
        step();
        chk("t4_sticky", {31'd0, underrun}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_clear", {31'd0, underrun}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);

        // Abort after 17 bits with a concurrent push, then a clean frame.
        push2_emit(32'h1234_5678, 32'h9ABC_DEF0, 17, 39);
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        bit_en  = 1'b1;
        step();
        abort   = 1'b0;
        s_valid = 1'b0;
        bit_en  = 1'b0;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_valid", {31'd0, bit_valid}, 32'd0);
        chk("t5_done", {31'd0, frame_done}, 32'd0);
        chk("t5_ready", {31'd0, s_ready}, 32'd1);
        step();
        chk("t5_drop", {31'd0, busy}, 32'd0);
        push2_emit(32'hF0F0_F0F0, 32'h0000_0033, 40, 39);

        // Lane b: reset mid-word returns every output to reset values.
        b_s_valid = 1'b1;
        b_s_data  = 32'h0000_000F;
        step();
        b_s_valid = 1'b0;
        step();
        b_bit_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_pre_bit", {31'd0, b_bit_out}, 32'd1);
        end
        b_rst     = 1'b1;
        b_s_valid = 1'b1;
        step();
        b_rst     = 1'b0;
        b_s_valid = 1'b0;
        b_bit_en  = 1'b0;
        chk("t6_rst_ready", {31'd0, b_s_ready}, 32'd1);
        chk("t6_rst_bit", {31'd0, b_bit_out}, 32'd0);
        chk("t6_rst_valid", {31'd0, b_bit_valid}, 32'd0);
        chk("t6_rst_done", {31'd0, b_frame_done}, 32'd0);
        chk("t6_rst_under", {31'd0, b_underrun}, 32'd0);
        chk("t6_rst_busy", {31'd0, b_busy}, 32'd0);

        // Full 784-bit frame from 25 words; last word's top half dropped.
        pushed    = 0;
        guard     = 0;
        b_s_valid = 1'b1;
        b_s_data  = wd(0);
        while (pushed < 9 && guard < 50) begin
            r = b_s_ready;
            step();
            guard++;
            if (r) begin
                pushed++;
            end
            b_s_data = wd(pushed);
        end
        chk("t6_prefill", 32'(pushed), 32'd9);
        chk("t6_full", {31'd0, b_s_ready}, 32'd0);
        b_bit_en = 1'b1;
        for (int j = 0; j < 784; j++) begin
            r = b_s_ready;
            v = b_s_valid;
            step();
            if (r && v) begin
                pushed++;
            end
            b_s_valid = (pushed < 25);
            b_s_data  = wd(pushed);
            w = wd(j / 32);
            chk("t6_valid", {31'd0, b_bit_valid}, 32'd1);
            chk("t6_bit", {31'd0, b_bit_out}, {31'd0, w[j%32]});
            chk("t6_done", {31'd0, b_frame_done}, {31'd0, j == 783});
            if (j == 783) begin
                b_bit_en = 1'b0;
                chk("t6_busy_end", {31'd0, b_busy}, 32'd0);
            end
        end
        chk("t6_pushed", 32'(pushed), 32'd25);
        step();
        chk("t6_valid_off", {31'd0, b_bit_valid}, 32'd0);
        chk("t6_under", {31'd0, b_underrun}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
